// File: rtl/nor_serial_ctrl.sv
// Bit-serial sequencer for an external 1-bit NOR cell: shifts two operands out LSB-first,
// gathers the cell output into a result word and flags any returned bit that is not !(x|y).
module nor_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_x,
  output logic             bit_y,
  input  logic             bit_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-2:0] a_sh;
  logic [WIDTH-2:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_next;

  // bit 0 of each operand goes straight into bit_x/bit_y; the shifters hold the rest
  assign res_next = {bit_o, res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      bit_x  <= 1'b0;
      bit_y  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_x <= 1'b0;
          bit_y <= 1'b0;
          if (start) begin
            a_sh  <= a[WIDTH-1:1];
            b_sh  <= b[WIDTH-1:1];
            bit_x <= a[0];
            bit_y <= b[0];
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_sh <= res_next[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          // a healthy cell returns the complement of (x|y)
          if (bit_o == (bit_x | bit_y)) err <= 1'b1;
          if (cnt == LAST) begin
            result <= res_next;
            done   <= 1'b1;
            bit_x  <= 1'b0;
            bit_y  <= 1'b0;
            state  <= DONE;
          end else begin
            bit_x <= a_sh[0];
            bit_y <= b_sh[0];
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
